lbuf_read_streamer: RTL and testbench
=====================================

LBUF_READ_STREAMER -- requirements
Module: lbuf_read_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width, matching local buffer.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, buffer address width (1024 words).
REQ-003 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset, asynchronous, active-low.
REQ-004 SHALL have ports: cmd_valid input 1; cmd_ready output 1; cmd_base input ADDR_WIDTH, start address; cmd_len input ADDR_WIDTH+1, word count 0..1024.
REQ-005 SHALL have port cmd_stride input ADDR_WIDTH, address increment; present only when LBUF_STRIDE_EN is defined.
REQ-006 SHALL have ports: buf_ce output 1; buf_we output 1; buf_addr output ADDR_WIDTH; buf_rdata input DATA_WIDTH. These drive the local buffer's ce/we/addr and receive its rdata.
REQ-007 SHALL have ports: m_valid output 1; m_ready input 1; m_data output DATA_WIDTH; m_last output 1, final word of the command.
REQ-008 SHALL have ports: busy output 1, command in progress; done output 1, single-cycle completion pulse.

Function
REQ-009 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-010 SHALL assert cmd_ready only in IDLE. A command is accepted on cmd_valid&&cmd_ready and its fields are latched.
REQ-011 On accept with cmd_len!=0, SHALL go to RUN. On accept with cmd_len==0, SHALL go to DONE without asserting buf_ce.
REQ-012 SHALL hold buf_we at 0 at all times.
REQ-013 In RUN, SHALL assert buf_ce in a cycle only if (reads in flight + output FIFO occupancy) < 2.
REQ-014 Each buf_ce cycle SHALL issue one read, advance buf_addr by stride, and decrement the remaining-issue counter.
REQ-015 SHALL compute address arithmetic modulo 2^ADDR_WIDTH; 1023+1 wraps to 0.
REQ-016 SHALL treat read latency as exactly 1 cycle: buf_rdata is sampled into the FIFO the cycle after buf_ce.
REQ-017 SHALL use a 2-entry output FIFO. m_valid equals FIFO non-empty; m_data and m_last come from the FIFO head.
REQ-018 While m_valid=1 and m_ready=0, m_data and m_last SHALL remain stable.
REQ-019 No FIFO entry SHALL ever be dropped or duplicated under any m_ready pattern.
REQ-020 SHALL tag m_last on the entry of the cmd_len-th read only.
REQ-021 After the last read issues, SHALL go RUN->DRAIN. On the m_last handshake, SHALL go DRAIN->DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-024 With m_ready held at 1 throughout, SHALL sustain one word per cycle; first m_valid comes 2 cycles after command accept.
REQ-025 A FIFO read and FIFO write in the same cycle SHALL be allowed at any occupancy, including full with a simultaneous pop.

Reset
REQ-026 On rst_n low, SHALL immediately enter IDLE and clear counters and FIFO, including mid-command. An in-flight read is discarded.
REQ-027 Reset values SHALL be: cmd_ready=1 (on first clock after release), buf_ce=0, buf_we=0, buf_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0.

Configuration
REQ-028 With macro LBUF_STRIDE_EN defined, the address increment SHALL be latched cmd_stride; stride 0 re-reads one address cmd_len times.
REQ-029 Without LBUF_STRIDE_EN, the cmd_stride port SHALL be absent and the increment fixed at 1.

Structure
REQ-030 DATA_WIDTH, ADDR_WIDTH and the FSM state encoding constants SHALL reside in shared package npu_pkg, alongside npu_definitions.
REQ-031 The 2-entry FIFO SHALL be sub-module lbuf_skid_fifo (push, pop, full, empty, data+last payload); all other logic SHALL stay in the top module.

Verification
REQ-032 Bench SHALL cover: base=0x010, len=4, m_ready=1 -> buf_addr 0x010..0x013 on consecutive cycles; m_data = preloaded words in order; m_last on 4th; done 1 cycle after.
REQ-033 Bench SHALL cover: base=0x3FE, len=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-034 Bench SHALL cover: len=8 with m_ready random 50% -> exactly 8 beats, in order, stable while stalled; buf_ce never asserted with 2 entries pending.
REQ-035 Bench SHALL cover: len=0 -> no buf_ce; done pulses; cmd_ready returns 1.
REQ-036 Bench SHALL cover: rst_n low during DRAIN of len=16 -> outputs at reset values; a following len=2 command completes correctly.
REQ-037 Bench SHALL cover, with LBUF_STRIDE_EN: base=0x000, len=3, stride=0x020 -> addresses 0x000, 0x020, 0x040.

Source files
------------

// File: rtl/npu_pkg.sv
// rtl/npu_pkg.sv - shared NPU definitions: data/address widths and local-buffer streamer FSM encoding
package npu_pkg;

  // npu_definitions: word and address sizes of the local buffer
  localparam int DATA_WIDTH      = 32;
  localparam int ADDR_WIDTH      = 10;
  localparam int LBUF_WORDS      = 1 << ADDR_WIDTH;
  localparam int LBUF_FIFO_DEPTH = 2;

  // Streamer FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } lbuf_state_e;

endpackage

// File: rtl/lbuf_skid_fifo.sv
// rtl/lbuf_skid_fifo.sv - 2-entry output FIFO carrying a data word plus its last flag
module lbuf_skid_fifo #(
  parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH:0] slot_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic                wr_en;
  logic                rd_en;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Head is forced to zero when empty so no stale word or last flag is ever shown
  assign head_data = empty ? '0   : slot_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign head_last = empty ? 1'b0 : slot_q[rd_ptr_q][DATA_WIDTH];

  // Storage, pointers and occupancy; simultaneous push/pop keeps the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        slot_q[wr_ptr_q] <= {push_last, push_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lbuf_read_streamer.sv
// rtl/lbuf_read_streamer.sv - streams cmd_len words from the local buffer onto m_*; LBUF_STRIDE_EN adds cmd_stride
module lbuf_read_streamer #(
  parameter int DATA_WIDTH = npu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = npu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH:0]   cmd_len,
`ifdef LBUF_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
`endif
  output logic                  buf_ce,
  output logic                  buf_we,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  input  logic [DATA_WIDTH-1:0] buf_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  import npu_pkg::*;

  localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  lbuf_state_e           state_q;
  lbuf_state_e           state_d;
  logic [ADDR_WIDTH:0]   rem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic                  rd_pend_q;
  logic                  rd_last_q;
  logic                  cmd_accept;
  logic                  m_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [1:0]            fifo_occ;
  logic [2:0]            pending;
  logic                  credit_ok;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign m_pop      = m_valid && m_ready;
  assign buf_we     = 1'b0;
  assign buf_addr   = addr_q;
  assign m_valid    = !fifo_empty;

  // Words owed downstream: read in flight plus FIFO entries, net of the word leaving this cycle.
  // Counting the departing word keeps one read issued per cycle while m_ready stays high.
  assign fifo_occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign pending   = 3'(rd_pend_q) + 3'(fifo_occ) - 3'(m_pop);
  assign credit_ok = (pending < 3'd2) && (rem_q != '0);

`ifdef LBUF_STRIDE_EN
  // Address increment is captured with the command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (cmd_accept) begin
      stride_q <= cmd_stride;
    end
  end
`else
  assign stride_q = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    buf_ce    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = (cmd_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        buf_ce = credit_ok;
        if (credit_ok && (rem_q == REM_ONE)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (m_pop && m_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Issue bookkeeping: remaining count, wrapping address, and the one-cycle read pipeline tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      addr_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_pend_q <= buf_ce;
      rd_last_q <= buf_ce && (rem_q == REM_ONE);
      if (cmd_accept) begin
        rem_q  <= cmd_len;
        addr_q <= cmd_base;
      end else if (buf_ce) begin
        rem_q  <= rem_q - REM_ONE;
        addr_q <= addr_q + stride_q;
      end
    end
  end

  lbuf_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_pend_q),
    .push_data (buf_rdata),
    .push_last (rd_last_q),
    .pop       (m_pop),
    .head_data (m_data),
    .head_last (m_last),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_lbuf_read_streamer.sv
// tb/tb_lbuf_read_streamer.sv - randomized self-checking bench for lbuf_read_streamer
module tb_lbuf_read_streamer;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int WORDS = 1024;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base  = '0;
  logic [AW:0]   cmd_len   = '0;
`ifdef LBUF_STRIDE_EN
  logic [AW-1:0] cmd_stride = '0;
`endif
  logic          buf_ce;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_rdata = '0;
  logic          m_valid;
  logic          m_ready   = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ready_mode = 0;

  logic [DW-1:0] mem [WORDS];

  int          iss_addr[$];
  int          iss_cyc[$];
  logic [DW-1:0] beat_data[$];
  logic        beat_last[$];
  int          beat_cyc[$];
  int          done_cyc[$];
  int          first_valid_cyc = -1;
  int          n_issued = 0;
  int          n_popped = 0;
  bit          prev_stall = 1'b0;
  logic [DW+1:0] prev_word = '0;

  lbuf_read_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
`ifdef LBUF_STRIDE_EN
    .cmd_stride(cmd_stride),
`endif
    .buf_ce    (buf_ce),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_rdata (buf_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Local buffer model: one-cycle read latency, garbage when not enabled
  always @(posedge clk) begin
    if (buf_ce) buf_rdata <= mem[buf_addr];
    else        buf_rdata <= $urandom;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: collects issued reads and accepted beats, checks stall stability and read credit
  always @(negedge clk) begin
    int pop;
    if (!rst_n) begin
      n_issued   = 0;
      n_popped   = 0;
      prev_stall = 1'b0;
    end else begin
      pop = (m_valid && m_ready) ? 1 : 0;
      if (prev_stall) check("stall_stable", {m_valid, m_last, m_data}, prev_word);
      if (buf_ce) begin
        check("ce_credit", 64'((n_issued - n_popped - pop) < 2), 64'd1);
        check("buf_we_low", buf_we, 1'b0);
        iss_addr.push_back(int'(buf_addr));
        iss_cyc.push_back(cyc);
        n_issued++;
      end
      if (pop == 1) begin
        beat_data.push_back(m_data);
        beat_last.push_back(m_last);
        beat_cyc.push_back(cyc);
        n_popped++;
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (done) done_cyc.push_back(cyc);
      prev_stall = m_valid && !m_ready;
      prev_word  = {1'b1, m_last, m_data};
    end
  end

  task automatic clear_logs();
    iss_addr.delete();
    iss_cyc.delete();
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    done_cyc.delete();
    first_valid_cyc = -1;
  endtask

  task automatic check_reset_values();
    check("rst_buf_ce",   buf_ce,   1'b0);
    check("rst_buf_we",   buf_we,   1'b0);
    check("rst_buf_addr", buf_addr, '0);
    check("rst_m_valid",  m_valid,  1'b0);
    check("rst_m_data",   m_data,   '0);
    check("rst_m_last",   m_last,   1'b0);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
  endtask

  task automatic start_cmd(input int base, input int len, output int acc_cyc);
    bit seen;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_base  = AW'(base);
    cmd_len   = (AW+1)'(len);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1'b1;
    end
    check("cmd_ready_seen", seen, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int base, input int len, input int stride, input int rmode);
    int acc_cyc;
    int bound;
    int addr_err;
    int data_err;
    int last_err;
    int time_err;
    bit fin;
    ready_mode = rmode;
    clear_logs();
`ifdef LBUF_STRIDE_EN
    cmd_stride = AW'(stride);
`endif
    start_cmd(base, len, acc_cyc);
    bound = len * 8 + 50;
    fin = 1'b0;
    for (int i = 0; i < bound && !fin; i++) begin
      @(negedge clk);
      if (done_cyc.size() != 0) fin = 1'b1;
    end
    check("done_seen", fin, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("ready_after_done", cmd_ready, 1'b1);
    check("idle_not_busy", busy, 1'b0);
    check("done_pulses", done_cyc.size(), 1);
    check("ce_count", iss_addr.size(), len);
    check("beat_count", beat_data.size(), len);
    addr_err = 0;
    data_err = 0;
    last_err = 0;
    time_err = 0;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i * stride) % WORDS;
      if (i < iss_addr.size() && iss_addr[i] != a) addr_err++;
      if (i < beat_data.size()) begin
        if (beat_data[i] !== mem[a]) data_err++;
        if (beat_last[i] !== (i == len - 1)) last_err++;
      end
      if (rmode == 0) begin
        if (i < iss_cyc.size() && iss_cyc[i] != acc_cyc + i) time_err++;
        if (i < beat_cyc.size() && beat_cyc[i] != acc_cyc + 2 + i) time_err++;
      end
    end
    check("addr_seq_errors", addr_err, 0);
    check("data_seq_errors", data_err, 0);
    check("last_tag_errors", last_err, 0);
    if (rmode == 0) check("one_per_cycle_errors", time_err, 0);
    if (rmode == 0 && len > 0) check("first_valid_latency", first_valid_cyc - acc_cyc, 2);
    if (len > 0 && beat_cyc.size() == len && done_cyc.size() > 0)
      check("done_after_last", done_cyc[0] - beat_cyc[len-1], 1);
    if (len == 0 && done_cyc.size() > 0)
      check("len0_done_cycle", done_cyc[0] - acc_cyc, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int acc_cyc;
    bit fin;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);

    run_cmd(32'h010, 4, 1, 0);
    run_cmd(32'h3FE, 4, 1, 0);
    run_cmd($urandom_range(0, WORDS-1), 8, 1, 1);
    run_cmd($urandom_range(0, WORDS-1), 0, 1, 0);
    for (int k = 0; k < 6; k++) begin
      run_cmd($urandom_range(0, WORDS-1), $urandom_range(1, 24), 1, $urandom_range(0, 1));
    end
    run_cmd($urandom_range(0, WORDS-1), 1024, 1, 0);

    // Reset while the last words of a len=16 command are still draining
    ready_mode = 0;
    clear_logs();
`ifdef LBUF_STRIDE_EN
    cmd_stride = AW'(1);
`endif
    start_cmd($urandom_range(0, WORDS-1), 16, acc_cyc);
    fin = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      if (iss_addr.size() >= 16) fin = 1'b1;
    end
    check("reach_drain", fin, 1'b1);
    @(posedge clk);
    #2;
    check("drain_busy", busy, 1'b1);
    check("drain_has_data", m_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_back", cmd_ready, 1'b1);
    run_cmd($urandom_range(0, WORDS-1), 2, 1, 1);

`ifdef LBUF_STRIDE_EN
    run_cmd(32'h000, 3, 32'h020, 0);
    run_cmd($urandom_range(0, WORDS-1), 5, 0, 1);
    run_cmd($urandom_range(0, WORDS-1), 12, $urandom_range(0, WORDS-1), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
